// File: rtl/add_sub_pipe_pkg.sv
// Shared constants for the pipelined adder/subtractor: mode encoding and
// bit positions inside the registered flag vector.
package add_sub_pipe_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_NEG  = 2;
    localparam int FLAG_W    = 3;

endpackage

// File: rtl/add_sub_pipe_chunk.sv
// CW-bit combinational ripple adder slice; one instance per pipeline stage.
module add_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/add_sub_pipe.sv
// Carry-pipelined add/subtract: stage k adds operand chunk k with the carry
// registered by stage k-1; the last stage also registers the result flags.
module add_sub_pipe
    import add_sub_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}});

    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic              c_q   [STAGES];
    logic              c_d   [STAGES];
    logic              vld_q [STAGES];
    logic              vld_d [STAGES];
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    logic [WIDTH-1:0]  nxt_a [STAGES];
    logic [WIDTH-1:0]  nxt_b [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic              nxt_c [STAGES];

    logic stall;

    assign stall    = vld_q[L] && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [CW-1:0]    chunk_sum;
        logic             chunk_cout;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + ~borrow, so the stage-0 operands are pre-inverted.
            assign src_a = inp1;
            assign src_b = (mode == MODE_ADD) ? inp2 : ~inp2;
            assign src_c = (mode == MODE_SUB) ? ~cin : cin;
            assign src_s = '0;
        end else begin : g_next
            assign src_a = a_q[k-1];
            assign src_b = b_q[k-1];
            assign src_c = c_q[k-1];
            assign src_s = s_q[k-1];
        end

        add_chunk #(.CW(CW)) u_chunk (
            .a    (src_a[k*CW +: CW]),
            .b    (src_b[k*CW +: CW]),
            .cin  (src_c),
            .sum  (chunk_sum),
            .cout (chunk_cout)
        );

        assign nxt_a[k] = src_a;
        assign nxt_b[k] = src_b;
        assign nxt_c[k] = chunk_cout;
        assign nxt_s[k] = (src_s & ~(CHUNK_MASK << (k * CW)))
                        | (WIDTH'(chunk_sum) << (k * CW));
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            c_d[k]   = c_q[k];
            vld_d[k] = vld_q[k];
        end
        flags_d = flags_q;

        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_d[k] = nxt_a[k];
                b_d[k] = nxt_b[k];
                s_d[k] = nxt_s[k];
                c_d[k] = nxt_c[k];
            end
            vld_d[0] = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            flags_d[FLAG_OVF]  = (nxt_a[L][WIDTH-1] == nxt_b[L][WIDTH-1])
                              && (nxt_s[L][WIDTH-1] != nxt_a[L][WIDTH-1]);
            flags_d[FLAG_ZERO] = (nxt_s[L] == '0);
            flags_d[FLAG_NEG]  = nxt_s[L][WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath flops are cleared too so the result outputs read zero after reset.
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            flags_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                vld_q[k] <= vld_d[k];
            end
            flags_q <= flags_d;
        end
    end

    assign out_valid = vld_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = flags_q[FLAG_OVF];
    assign zero      = flags_q[FLAG_ZERO];
    assign neg       = flags_q[FLAG_NEG];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: a 16-bit/4-stage instance and an
// 8-bit/1-stage instance, checked against hand-computed results.
module tb_add_sub_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, mode, out_valid, out_ready;
    logic [15:0] inp1, inp2, sum;
    logic        cout, ovf, zero, neg;

    logic        in_valid1, in_ready1, cin1, mode1, out_valid1, out_ready1;
    logic [7:0]  inp1_1, inp2_1, sum1;
    logic        cout1, ovf1, zero1, neg1;

    int checks   = 0;
    int failures = 0;

    // Stream vectors: a, b, cin, mode, expected sum, expected cout.
    logic [15:0] va [8] = '{16'h0001, 16'h1000, 16'h0010, 16'hFFFF, 16'h0000, 16'h0F0F, 16'h1234, 16'h8000};
    logic [15:0] vb [8] = '{16'h0002, 16'h2000, 16'h0001, 16'hFFFF, 16'h0001, 16'hF0F0, 16'h0234, 16'h8000};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        vm [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] es [8] = '{16'h0003, 16'h3001, 16'h000F, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0FFF, 16'h0000};
    logic        ec [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp1      (inp1),
        .inp2      (inp2),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    add_sub_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .inp1      (inp1_1),
        .inp2      (inp2_1),
        .cin       (cin1),
        .mode      (mode1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1),
        .zero      (zero1),
        .neg       (neg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation on the 4-stage instance, checking exact latency.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic m, input logic [15:0] e_sum,
                          input logic e_cout, input logic e_ovf, input logic e_zero,
                          input logic e_neg);
        in_valid = 1'b1;
        inp1 = a;
        inp2 = b;
        cin  = c;
        mode = m;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check({tag, "_early"}, out_valid, 1'b0);
            tick();
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"},   sum,   e_sum);
        check({tag, "_cout"},  cout,  e_cout);
        check({tag, "_ovf"},   ovf,   e_ovf);
        check({tag, "_zero"},  zero,  e_zero);
        check({tag, "_neg"},   neg,   e_neg);
        tick();
        check({tag, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        int iidx;
        int oidx;
        int cyc;
        logic seen;

        rst_n = 1'b0;
        in_valid = 1'b0; inp1 = '0; inp2 = '0; cin = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; inp1_1 = '0; inp2_1 = '0; cin1 = 1'b0; mode1 = 1'b0; out_ready1 = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_flags", {cout, ovf, zero, neg}, 4'b0000);
        check("rst1_out_valid", out_valid1, 1'b0);
        check("rst1_sum", sum1, 8'h00);

        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1'b1);

        run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("add_chunkc", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_equal",  16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream with out_ready dropped for cycles 5..7.
        iidx = 0;
        oidx = 0;
        cyc  = 0;
        while (oidx < 8 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (out_valid && out_ready) begin
                check("stream_sum",  sum,  es[oidx]);
                check("stream_cout", cout, ec[oidx]);
                check("stream_zero", zero, (es[oidx] == 16'h0000));
                check("flow_in_ready", in_ready, 1'b1);
                oidx++;
            end else if (out_valid) begin
                check("stall_in_ready", in_ready, 1'b0);
                check("stall_hold_sum", sum, es[oidx]);
                check("stall_hold_cout", cout, ec[oidx]);
            end
            if (in_ready && iidx < 8) begin
                in_valid = 1'b1;
                inp1 = va[iidx];
                inp2 = vb[iidx];
                cin  = vc[iidx];
                mode = vm[iidx];
                iidx++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", oidx, 8);
        tick();
        check("stream_empty", out_valid, 1'b0);

        // Three operations in flight, then a one-cycle reset pulse.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            inp1 = 16'h0100 + 16'(i);
            inp2 = 16'h0001;
            cin  = 1'b0;
            mode = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, 16'h0000);
        check("midrst_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_emit", seen, 1'b0);

        // Single-stage 8-bit instance: latency of one cycle.
        in_valid1 = 1'b1;
        inp1_1 = 8'h80;
        inp2_1 = 8'h80;
        cin1   = 1'b0;
        mode1  = 1'b0;
        tick();
        check("s1_add_valid", out_valid1, 1'b1);
        check("s1_add_sum",   sum1, 8'h00);
        check("s1_add_flags", {cout1, ovf1, zero1, neg1}, 4'b1110);
        inp1_1 = 8'h10;
        inp2_1 = 8'h20;
        mode1  = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("s1_sub_valid", out_valid1, 1'b1);
        check("s1_sub_sum",   sum1, 8'hF0);
        check("s1_sub_flags", {cout1, ovf1, zero1, neg1}, 4'b0001);
        tick();
        check("s1_drain", out_valid1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
